// File: rtl/key_load_ctrl.sv
// Serial key loader for the locked c499 netlist: receives a CRC-8 protected key frame
// and commits it to the mux/XOR key bits. Optional macro KEY_ZEROIZE_EN adds a zeroize input.
module key_load_ctrl #(
    parameter int unsigned KEY_W    = 44,
    parameter int unsigned MUX_W    = 4,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sdi,
    input  logic                   sdi_valid,
`ifdef KEY_ZEROIZE_EN
    input  logic                   zeroize,
`endif
    output logic                   sdi_ready,
    output logic [MUX_W-1:0]       key_mux,
    output logic [KEY_W-MUX_W-1:0] key_xor,
    output logic                   key_ok,
    output logic                   busy,
    output logic                   err,
    output logic [3:0]             fail_cnt,
    output logic                   lockout
);

    localparam int unsigned FRAME_W = KEY_W + 8;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam logic [7:0]  POLY    = 8'h07;
    localparam logic [3:0]  FAIL_MAX = 4'(MAX_FAIL);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_LOCKOUT = 2'd3;

    logic [1:0]       rst_sync;
    logic             rst_i_n;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [7:0]       crc_q,    crc_d;
    logic [7:0]       rxcrc_q,  rxcrc_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_q,    key_d;
    logic             key_ok_d, err_d, ready_d, busy_d, lockout_d;
    logic [3:0]       fail_d,   fail_inc;
    logic             fb;

    // Reset asserts asynchronously but releases in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            crc_q     <= '0;
            rxcrc_q   <= '0;
            shadow_q  <= '0;
            key_q     <= '0;
            key_ok    <= 1'b0;
            err       <= 1'b0;
            fail_cnt  <= '0;
            sdi_ready <= 1'b0;
            busy      <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            rxcrc_q   <= rxcrc_d;
            shadow_q  <= shadow_d;
            key_q     <= key_d;
            key_ok    <= key_ok_d;
            err       <= err_d;
            fail_cnt  <= fail_d;
            sdi_ready <= ready_d;
            busy      <= busy_d;
            lockout   <= lockout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        rxcrc_d  = rxcrc_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        key_ok_d = key_ok;
        err_d    = 1'b0;
        fail_d   = fail_cnt;
        fb       = crc_q[7] ^ sdi;
        fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 4'd1;

        case (state_q)
            S_IDLE, S_SHIFT: begin
                if (start) begin
                    // Begin, or abort and restart, a frame; committed key is untouched.
                    state_d  = S_SHIFT;
                    cnt_d    = '0;
                    crc_d    = '0;
                    rxcrc_d  = '0;
                    shadow_d = '0;
                end else if (state_q == S_SHIFT && sdi_valid) begin
                    if (cnt_q < CNT_W'(KEY_W)) begin
                        shadow_d[cnt_q] = sdi;
                        crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
                    end else begin
                        rxcrc_d = {rxcrc_q[6:0], sdi};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (crc_q == rxcrc_q) begin
                    key_d    = shadow_q;
                    key_ok_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    key_d    = '0;
                    key_ok_d = 1'b0;
                    err_d    = 1'b1;
                    fail_d   = fail_inc;
                    state_d  = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                end
            end
            default: begin
                key_d    = '0;
                key_ok_d = 1'b0;
            end
        endcase

`ifdef KEY_ZEROIZE_EN
        if (zeroize && state_q != S_LOCKOUT) begin
            key_d    = '0;
            key_ok_d = 1'b0;
            shadow_d = '0;
            cnt_d    = '0;
            crc_d    = '0;
            rxcrc_d  = '0;
            state_d  = S_IDLE;
        end
`endif

        ready_d   = (state_d == S_SHIFT);
        busy_d    = (state_d == S_SHIFT) || (state_d == S_CHECK);
        lockout_d = (state_d == S_LOCKOUT);
    end

    assign key_mux = key_q[MUX_W-1:0];
    assign key_xor = key_q[KEY_W-1:MUX_W];

endmodule
